l2_way_select: RTL and testbench

- Consumes the registered result of the L2 tag lookup stage: tag hit, hit way, empty-way found and empty way.
- Decides which way the L2 controller uses for a request: the hit way, an empty way, or a round-robin eviction victim that skips busy ways.
- Produces the victim way that the lookup stage later receives as its eviction-way buffer.
- Keeps one round-robin eviction pointer per set.

---
 rtl/l2_way_select.sv | 162 ++++++++++++++++
 tb/tb_l2_way_select.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/l2_way_select.sv
// l2_way_select: chooses the way the L2 controller uses for a request.
// A hit wins over an empty way. With neither, a round-robin scan starting at
// the per-set eviction pointer picks the first way not marked busy. If every
// way is busy, the result is STALL.
// Optional build macro L2_WAY_SELECT_STATS_EN adds four 16-bit saturating
// selection counters and a synchronous clear input.
module l2_way_select #(
  parameter int unsigned SETS     = 256,
  parameter int unsigned WAYS     = 8,
  parameter int unsigned SET_BITS = 8,
  parameter int unsigned WAY_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  output logic                lookup_ready,
  input  logic [SET_BITS-1:0] set,
  input  logic                tag_hit,
  input  logic [WAY_BITS-1:0] way_hit,
  input  logic                empty_way_found,
  input  logic [WAY_BITS-1:0] empty_way,
  input  logic [WAYS-1:0]     busy_mask,
  output logic                sel_valid,
  input  logic                sel_ready,
  output logic [WAY_BITS-1:0] sel_way,
  output logic [1:0]          sel_kind
`ifdef L2_WAY_SELECT_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         stat_hit,
  output logic [15:0]         stat_empty,
  output logic [15:0]         stat_evict,
  output logic [15:0]         stat_stall
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OUT} state_t;
  typedef enum logic [1:0] {
    KIND_HIT   = 2'd0,
    KIND_EMPTY = 2'd1,
    KIND_EVICT = 2'd2,
    KIND_STALL = 2'd3
  } kind_t;

  state_t              state;
  kind_t               kind_q;
  logic [SET_BITS-1:0] set_q;
  logic [WAYS-1:0]     busy_q;
  logic [WAY_BITS-1:0] base_q;
  logic [WAY_BITS-1:0] idx_q;
  logic [WAY_BITS-1:0] way_q;
  logic                valid_q;
  logic [WAY_BITS-1:0] ptr [SETS];

  logic [WAY_BITS-1:0] cand;
  logic                handshake;

  // Candidate way for the current scan step; WAY_BITS-wide sum wraps naturally
  always_comb begin
    cand      = base_q + idx_q;
    handshake = (state == ST_OUT) && valid_q && sel_ready;
  end

  assign lookup_ready = (state == ST_IDLE) && !rst;
  assign sel_valid    = valid_q;
  assign sel_way      = way_q;
  assign sel_kind     = kind_q;

  // Selection FSM, pointer table and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      kind_q  <= KIND_HIT;
      set_q   <= '0;
      busy_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        ptr[s] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (lookup_valid) begin
            set_q  <= set;
            busy_q <= busy_mask;
            idx_q  <= '0;
            base_q <= ptr[set];
            if (tag_hit) begin
              way_q   <= way_hit;
              kind_q  <= KIND_HIT;
              valid_q <= 1'b1;
              state   <= ST_OUT;
            end else if (empty_way_found) begin
              way_q   <= empty_way;
              kind_q  <= KIND_EMPTY;
              valid_q <= 1'b1;
              state   <= ST_OUT;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (!busy_q[cand]) begin
            way_q   <= cand;
            kind_q  <= KIND_EVICT;
            valid_q <= 1'b1;
            state   <= ST_OUT;
          end else if (idx_q == WAY_BITS'(WAYS - 1)) begin
            way_q   <= base_q;
            kind_q  <= KIND_STALL;
            valid_q <= 1'b1;
            state   <= ST_OUT;
          end else begin
            idx_q <= idx_q + WAY_BITS'(1);
          end
        end
        ST_OUT: begin
          if (handshake) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
            if (kind_q == KIND_EVICT) begin
              ptr[set_q] <= way_q + WAY_BITS'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef L2_WAY_SELECT_STATS_EN
  // Saturating per-kind counters of accepted selections; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit   <= '0;
      stat_empty <= '0;
      stat_evict <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_hit   <= '0;
      stat_empty <= '0;
      stat_evict <= '0;
      stat_stall <= '0;
    end else if (handshake) begin
      case (kind_q)
        KIND_HIT:   if (stat_hit   != '1) stat_hit   <= stat_hit   + 16'd1;
        KIND_EMPTY: if (stat_empty != '1) stat_empty <= stat_empty + 16'd1;
        KIND_EVICT: if (stat_evict != '1) stat_evict <= stat_evict + 16'd1;
        default:    if (stat_stall != '1) stat_stall <= stat_stall + 16'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_l2_way_select.sv
// Scoreboard bench for l2_way_select: the driver pushes hand-computed
// expectations, and a monitor pops them when sel_valid rises.
module tb_l2_way_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lookup_valid = 1'b0;
  logic       lookup_ready;
  logic [7:0] set = '0;
  logic       tag_hit = 1'b0;
  logic [2:0] way_hit = '0;
  logic       empty_way_found = 1'b0;
  logic [2:0] empty_way = '0;
  logic [7:0] busy_mask = '0;
  logic       sel_valid;
  logic       sel_ready = 1'b0;
  logic [2:0] sel_way;
  logic [1:0] sel_kind;
`ifdef L2_WAY_SELECT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_hit, stat_empty, stat_evict, stat_stall;
`endif

  l2_way_select #(.SETS(256), .WAYS(8), .SET_BITS(8), .WAY_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .set(set), .tag_hit(tag_hit), .way_hit(way_hit),
    .empty_way_found(empty_way_found), .empty_way(empty_way),
    .busy_mask(busy_mask),
    .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_way(sel_way), .sel_kind(sel_kind)
`ifdef L2_WAY_SELECT_STATS_EN
    , .stat_clr(stat_clr), .stat_hit(stat_hit), .stat_empty(stat_empty),
    .stat_evict(stat_evict), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int way;
    int lat;
    int hold;
    int acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 1'b0;
  int   held   = 0;
  int   tests  = 0;
  int   fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on each new selection and checks it is held
  initial begin
    forever begin
      @(negedge clk);
      if (sel_valid === 1'b1) begin
        if (!active) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_sel: kind %0d way %0d", sel_kind, sel_way);
            sel_ready = 1'b1;
          end else begin
            cur    = q.pop_front();
            active = 1'b1;
            held   = 0;
            check("sel_kind", int'(sel_kind), cur.kind);
            check("sel_way", int'(sel_way), cur.way);
            check("latency", cyc - cur.acc, cur.lat);
            sel_ready = (cur.hold == 0);
          end
        end else begin
          held++;
          check("hold_stable", {29'd0, sel_kind, sel_way}, (cur.kind << 3) | cur.way);
          sel_ready = (held >= cur.hold);
        end
        if (sel_ready) active = 1'b0;
      end else begin
        sel_ready = 1'b0;
      end
    end
  end

  task automatic issue(input int s, input bit hit, input int wh, input bit ef,
                       input int ew, input int busy, input int ek, input int ewy,
                       input int elat, input int hold, input bit push);
    int n = 0;
    @(negedge clk);
    while (lookup_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (lookup_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    set = s[7:0]; tag_hit = hit; way_hit = wh[2:0];
    empty_way_found = ef; empty_way = ew[2:0]; busy_mask = busy[7:0];
    lookup_valid = 1'b1;
    if (push) q.push_back('{kind: ek, way: ewy, lat: elat, hold: hold, acc: cyc});
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    // Flip the live mask; the scan must keep using the latched copy
    busy_mask = ~busy[7:0];
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || active || lookup_ready !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("done_timeout", 0, 1);
  endtask

  // Evict request with no hit and no empty way; way_hit/empty_way are decoys
  task automatic evict(input int s, input int busy, input int ek, input int ewy,
                       input int elat, input int hold);
    issue(s, 1'b0, 5, 1'b0, 3, busy, ek, ewy, elat, hold, 1'b1);
    wait_done();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel_valid", int'(sel_valid), 0);
    check("rst_sel_way", int'(sel_way), 0);
    check("rst_sel_kind", int'(sel_kind), 0);
`ifdef L2_WAY_SELECT_STATS_EN
    check("rst_stat_hit", int'(stat_hit), 0);
    check("rst_stat_evict", int'(stat_evict), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_lookup_ready", int'(lookup_ready), 1);

    issue(5, 1'b1, 6, 1'b0, 0, 8'h00, 0, 6, 1, 0, 1'b1); wait_done();
    issue(3, 1'b0, 7, 1'b1, 2, 8'h00, 1, 2, 1, 1, 1'b1); wait_done();
    issue(4, 1'b1, 3, 1'b1, 1, 8'h00, 0, 3, 1, 0, 1'b1); wait_done();
    evict(5, 8'h00, 2, 0, 2, 0);     // HIT left ptr[5] at 0
    evict(7, 8'h00, 2, 0, 2, 3);     // held 3 cycles; ptr[7] -> 1
    evict(7, 8'h00, 2, 1, 2, 0);     // ptr[7] -> 2
    evict(9, 8'h00, 2, 0, 2, 0);     // ptr[9] -> 1
    evict(9, 8'h0E, 2, 4, 5, 0);     // skip 1..3; ptr[9] -> 5
    evict(9, 8'h00, 2, 5, 2, 1);     // ptr[9] -> 6
    evict(9, 8'hFF, 3, 6, 9, 2);     // STALL at base; ptr unchanged
    evict(9, 8'h00, 2, 6, 2, 0);     // ptr[9] -> 7
    evict(9, 8'h80, 2, 0, 3, 0);     // 7 busy, wraps to 0; ptr[9] -> 1

    // Reset in the middle of an all-busy scan
    issue(9, 1'b0, 0, 1'b0, 0, 8'hFF, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midscan_sel_valid", int'(sel_valid), 0);
    check("midscan_lookup_ready", int'(lookup_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    evict(9, 8'h00, 2, 0, 2, 0);
    evict(7, 8'h00, 2, 0, 2, 0);

`ifdef L2_WAY_SELECT_STATS_EN
    check("stat_evict_after_rst", int'(stat_evict), 2);
    stat_clr = 1'b1;
    issue(5, 1'b1, 1, 1'b0, 0, 8'h00, 0, 1, 1, 0, 1'b1); wait_done();
    check("stat_hit_clr_wins", int'(stat_hit), 0);
    stat_clr = 1'b0;
    issue(5, 1'b1, 2, 1'b0, 0, 8'h00, 0, 2, 1, 0, 1'b1); wait_done();
    check("stat_hit_inc", int'(stat_hit), 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
